// File: rtl/flappy_pkg.sv
// Shared types and matrix constants for the Flappy Bird LED-matrix game logic.
package flappy_pkg;

    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 16;

    typedef enum logic [1:0] {
        HIT_NONE  = 2'd0,
        HIT_PIPE  = 2'd1,
        HIT_CEIL  = 2'd2,
        HIT_FLOOR = 2'd3
    } hit_kind_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_REPORT = 2'd2
    } scan_state_e;

endpackage

// File: rtl/collision_scanner_if.sv
// Frame input / collision result bundle between the render logic and the scanner.
interface collision_scanner_if
    import flappy_pkg::*;
#(
    parameter int ROWS = MATRIX_ROWS,
    parameter int COLS = MATRIX_COLS
);
    localparam int RW = $clog2(ROWS);

    logic                 frame_valid;
    logic                 press;
    logic [ROWS*COLS-1:0] red;
    logic [ROWS*COLS-1:0] green;
    logic                 clear;
    logic                 busy;
    logic                 done;
    logic                 collision;
    hit_kind_e            hit_kind;
    logic [RW-1:0]        hit_row;
    logic                 overrun;

    modport master (
        output frame_valid, press, red, green, clear,
        input  busy, done, collision, hit_kind, hit_row, overrun
    );

    modport slave (
        input  frame_valid, press, red, green, clear,
        output busy, done, collision, hit_kind, hit_row, overrun
    );

endinterface

// File: rtl/collision_scanner.sv
// Snapshots the bird/pipe planes on each frame strobe, scans one row per clock
// and reports a typed, located collision with grace frames after a restart.
module collision_scanner
    import flappy_pkg::*;
#(
    parameter int ROWS      = MATRIX_ROWS,
    parameter int COLS      = MATRIX_COLS,
    parameter int BIRD_COL  = 14,
    parameter int LOOKAHEAD = 0,
    parameter int GRACE     = 2
) (
    input  logic             clk,
    input  logic             rst,
    collision_scanner_if.slave bus
);
    localparam int            RW              = $clog2(ROWS);
    localparam int            LA_COL          = (LOOKAHEAD != 0) ? BIRD_COL + 1 : BIRD_COL;
    localparam logic [RW-1:0] LAST_ROW        = RW'(ROWS - 1);
    localparam logic [7:0]    GRACE_INIT      = 8'(GRACE);
    localparam logic [7:0]    GRACE_AFTER_RPT = (GRACE > 0) ? 8'(GRACE - 1) : 8'd0;

    scan_state_e          state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 rec_found_q, rec_found_d;
    logic [RW-1:0]        rec_row_q, rec_row_d;
    logic [ROWS*COLS-1:0] red_q, green_q;
    logic                 press_q;
    logic [7:0]           grace_q;
    logic                 collision_q, overrun_q, done_q;
    hit_kind_e            kind_q, kind_s;
    logic [RW-1:0]        hit_row_q, res_row_s;
    logic [ROWS-1:0]      red_col_s, green_col_s, green_la_s;
    logic                 snap_en_s, busy_s, hit_now_s;

    function automatic logic row_hit(input logic bird, input logic pipe, input logic pipe_ahead);
        return bird & (pipe | pipe_ahead);
    endfunction

    // Extract the bird column (and optional look-ahead column) from the snapshots
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            red_col_s[r]   = red_q[r*COLS + BIRD_COL];
            green_col_s[r] = green_q[r*COLS + BIRD_COL];
            green_la_s[r]  = (LOOKAHEAD != 0) ? green_q[r*COLS + LA_COL] : 1'b0;
        end
    end

    assign snap_en_s = (state_q == S_IDLE) & bus.frame_valid;
    assign busy_s    = (state_q != S_IDLE);
    assign hit_now_s = row_hit(red_col_s[row_q], green_col_s[row_q], green_la_s[row_q]);

    // Next-state logic: accept, scan rows keeping the lowest hit, then report
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        rec_found_d = rec_found_q;
        rec_row_d   = rec_row_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_valid) begin
                    state_d     = S_SCAN;
                    row_d       = '0;
                    rec_found_d = 1'b0;
                    rec_row_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!rec_found_q && hit_now_s) begin
                    rec_found_d = 1'b1;
                    rec_row_d   = row_q;
                end else begin
                    rec_found_d = rec_found_q;
                end
                if (row_q == LAST_ROW) begin
                    state_d = S_REPORT;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            S_REPORT: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Frame result: a recorded pipe hit outranks ceiling, which outranks floor
    always_comb begin
        kind_s    = HIT_NONE;
        res_row_s = '0;
        if (rec_found_q) begin
            kind_s    = HIT_PIPE;
            res_row_s = rec_row_q;
        end else if (red_col_s[0] & press_q) begin
            kind_s    = HIT_CEIL;
            res_row_s = '0;
        end else if (red_col_s[ROWS-1] & ~press_q) begin
            kind_s    = HIT_FLOOR;
            res_row_s = LAST_ROW;
        end else begin
            kind_s    = HIT_NONE;
            res_row_s = '0;
        end
    end

    // FSM state, scan record and frame snapshot registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            rec_found_q <= 1'b0;
            rec_row_q   <= '0;
            red_q       <= '0;
            green_q     <= '0;
            press_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            rec_found_q <= rec_found_d;
            rec_row_q   <= rec_row_d;
            if (snap_en_s) begin
                red_q   <= bus.red;
                green_q <= bus.green;
                press_q <= bus.press;
            end
        end
    end

    // Reported result, sticky flags and grace counter; clear beats a same-cycle report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q      <= 1'b0;
            kind_q      <= HIT_NONE;
            hit_row_q   <= '0;
            collision_q <= 1'b0;
            overrun_q   <= 1'b0;
            grace_q     <= GRACE_INIT;
        end else begin
            done_q <= (state_q == S_REPORT);
            if (state_q == S_REPORT) begin
                kind_q    <= kind_s;
                hit_row_q <= res_row_s;
            end
            if (bus.clear) begin
                collision_q <= 1'b0;
                overrun_q   <= 1'b0;
                grace_q     <= (state_q == S_REPORT) ? GRACE_AFTER_RPT : GRACE_INIT;
            end else begin
                if (state_q == S_REPORT) begin
                    if (grace_q != 8'd0) begin
                        grace_q <= grace_q - 8'd1;
                    end else if (kind_s != HIT_NONE) begin
                        collision_q <= 1'b1;
                    end
                end
                if (busy_s && bus.frame_valid) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = busy_s;
    assign bus.done      = done_q;
    assign bus.collision = collision_q;
    assign bus.hit_kind  = kind_q;
    assign bus.hit_row   = hit_row_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: three configurations share one stimulus stream,
// a reference model queues expected frame results checked on every done pulse.
module tb_collision_scanner;
    import flappy_pkg::*;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] row;
        logic       coll;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_valid_s, press_s, clear_s;
    logic [255:0] red_s, green_s;
    int           vectors = 0;
    int           miscompares = 0;

    exp_t q0[$], q1[$], q2[$];
    int   grace_m[3];
    bit   coll_m[3];
    int   grace_cfg[3] = '{0, 2, 0};

    logic [2:0] busy_w, done_w, coll_w, ovr_w;
    logic [1:0] kind_w[3];
    logic [3:0] row_w[3];

    always #5 clk = ~clk;

    collision_scanner_if #(.ROWS(16), .COLS(16)) if0 ();
    collision_scanner_if #(.ROWS(16), .COLS(16)) if1 ();
    collision_scanner_if #(.ROWS(16), .COLS(16)) if2 ();

    assign if0.frame_valid = frame_valid_s; assign if1.frame_valid = frame_valid_s; assign if2.frame_valid = frame_valid_s;
    assign if0.press = press_s;   assign if1.press = press_s;   assign if2.press = press_s;
    assign if0.red   = red_s;     assign if1.red   = red_s;     assign if2.red   = red_s;
    assign if0.green = green_s;   assign if1.green = green_s;   assign if2.green = green_s;
    assign if0.clear = clear_s;   assign if1.clear = clear_s;   assign if2.clear = clear_s;

    assign busy_w = {if2.busy, if1.busy, if0.busy};
    assign done_w = {if2.done, if1.done, if0.done};
    assign coll_w = {if2.collision, if1.collision, if0.collision};
    assign ovr_w  = {if2.overrun, if1.overrun, if0.overrun};
    assign kind_w[0] = if0.hit_kind; assign kind_w[1] = if1.hit_kind; assign kind_w[2] = if2.hit_kind;
    assign row_w[0]  = if0.hit_row;  assign row_w[1]  = if1.hit_row;  assign row_w[2]  = if2.hit_row;

    collision_scanner #(.ROWS(16), .COLS(16), .BIRD_COL(14), .LOOKAHEAD(0), .GRACE(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    collision_scanner #(.ROWS(16), .COLS(16), .BIRD_COL(14), .LOOKAHEAD(0), .GRACE(2))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    collision_scanner #(.ROWS(16), .COLS(16), .BIRD_COL(14), .LOOKAHEAD(1), .GRACE(0))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic int pix(input int r, input int c);
        return r * 16 + c;
    endfunction

    // Reference model: compute the frame result and advance grace/collision state.
    function automatic exp_t model_frame(input int d, input logic [255:0] rp, input logic [255:0] gp,
                                         input logic p, input bit clear_in_report);
        exp_t e;
        bit   found = 0;
        e.kind = HIT_NONE;
        e.row  = 4'd0;
        for (int r = 0; r < 16; r++) begin
            if (!found && rp[pix(r, 14)] && (gp[pix(r, 14)] || (d == 2 && gp[pix(r, 15)]))) begin
                found  = 1;
                e.kind = HIT_PIPE;
                e.row  = 4'(r);
            end
        end
        if (!found) begin
            if (rp[pix(0, 14)] && p) begin
                e.kind = HIT_CEIL;  e.row = 4'd0;
            end else if (rp[pix(15, 14)] && !p) begin
                e.kind = HIT_FLOOR; e.row = 4'd15;
            end
        end
        if (clear_in_report) begin
            coll_m[d]  = 0;
            grace_m[d] = (grace_cfg[d] > 0) ? grace_cfg[d] - 1 : 0;
        end else if (grace_m[d] > 0) begin
            grace_m[d] = grace_m[d] - 1;
        end else if (e.kind != HIT_NONE) begin
            coll_m[d] = 1;
        end
        e.coll = coll_m[d];
        return e;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            grace_m[d] = grace_cfg[d];
            coll_m[d]  = 0;
        end
        q0.delete(); q1.delete(); q2.delete();
    endfunction

    task automatic send_frame(input logic [255:0] rp, input logic [255:0] gp, input logic p,
                              input bit push, input bit clear_in_report);
        red_s = rp; green_s = gp; press_s = p; frame_valid_s = 1'b1;
        if (push) begin
            q0.push_back(model_frame(0, rp, gp, p, clear_in_report));
            q1.push_back(model_frame(1, rp, gp, p, clear_in_report));
            q2.push_back(model_frame(2, rp, gp, p, clear_in_report));
        end
        @(posedge clk); #1;
        frame_valid_s = 1'b0;
    endtask

    task automatic do_clear();
        clear_s = 1'b1;
        @(posedge clk); #1;
        clear_s = 1'b0;
        for (int d = 0; d < 3; d++) begin
            coll_m[d]  = 0;
            grace_m[d] = grace_cfg[d];
        end
    endtask

    // Waits for done on dut0; returns the number of edges after the accept edge.
    task automatic wait_done(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_w[0]) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n == 0) begin
            miscompares++;
            $display("FAIL %s_timeout: no done within 40 cycles, required done", name);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result per configuration.
    always begin
        exp_t e;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            if (done_w[d]) begin
                vectors++;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0) || (d == 2 && q2.size() == 0)) begin
                    miscompares++;
                    $display("FAIL unexpected_done dut%0d: got done=1, required no done", d);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else if (d == 1) e = q1.pop_front();
                    else e = q2.pop_front();
                    if ({kind_w[d], row_w[d], coll_w[d]} !== {e.kind, e.row, e.coll}) begin
                        miscompares++;
                        $display("FAIL result dut%0d: got kind=%0d row=%0d coll=%0b, required kind=%0d row=%0d coll=%0b",
                                 d, kind_w[d], row_w[d], coll_w[d], e.kind, e.row, e.coll);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        vectors++;
        if ({busy_w, done_w, coll_w, ovr_w} !== 12'd0 || {kind_w[0], kind_w[1], kind_w[2]} !== 6'd0 ||
            {row_w[0], row_w[1], row_w[2]} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b coll=%b ovr=%b, required all 0", busy_w, done_w, coll_w, ovr_w);
        end
    endtask

    task automatic test_pipe_basic();
        logic [255:0] rp, gp;
        int n;
        rp = '0; gp = '0;
        rp[pix(7, 14)] = 1'b1; gp[pix(7, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0);
        vectors++;
        if (busy_w !== 3'b111) begin
            miscompares++;
            $display("FAIL busy_in_scan: got %b, required 111", busy_w);
        end
        wait_done("pipe_basic", n);
        vectors++;
        if (n + 1 != 18) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, required 18", n + 1);
        end
        @(posedge clk); #1;
        vectors++;
        if (done_w !== 3'b000 || busy_w !== 3'b000) begin
            miscompares++;
            $display("FAIL done_pulse_width: got done=%b busy=%b, required 000 000", done_w, busy_w);
        end
    endtask

    task automatic test_priority();
        logic [255:0] rp, gp;
        int n;
        rp = '0; gp = '0;
        rp[pix(3, 14)] = 1'b1; rp[pix(9, 14)] = 1'b1; gp[pix(3, 14)] = 1'b1; gp[pix(9, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0); wait_done("first_row", n);
        rp = '0; gp = '0; rp[pix(0, 14)] = 1'b1;
        send_frame(rp, gp, 1'b1, 1, 0); wait_done("ceil", n);
        rp = '0; rp[pix(15, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0); wait_done("floor", n);
        rp = '0; rp[pix(0, 14)] = 1'b1; rp[pix(5, 14)] = 1'b1; gp[pix(5, 14)] = 1'b1;
        send_frame(rp, gp, 1'b1, 1, 0); wait_done("pipe_over_ceil", n);
        rp = '0; gp = '0; rp[pix(0, 14)] = 1'b1; rp[pix(15, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0); wait_done("floor_not_ceil", n);
    endtask

    task automatic test_grace();
        logic [255:0] rp, gp;
        int n;
        rp = '0; gp = '0; rp[pix(2, 14)] = 1'b1; gp[pix(2, 14)] = 1'b1;
        do_clear();
        vectors++;
        if (coll_w !== 3'b000) begin
            miscompares++;
            $display("FAIL clear_collision: got %b, required 000", coll_w);
        end
        for (int f = 0; f < 3; f++) begin
            send_frame(rp, gp, 1'b0, 1, 0);
            wait_done("grace", n);
        end
        vectors++;
        if (coll_w[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL grace_third_frame: got collision=%b, required 1", coll_w[1]);
        end
    endtask

    task automatic test_overrun();
        logic [255:0] rp, gp, rb;
        int n, extra;
        rp = '0; gp = '0; rp[pix(6, 14)] = 1'b1; gp[pix(6, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        rb = '0; rb[pix(1, 14)] = 1'b1; rb[pix(0, 14)] = 1'b1;
        send_frame(rb, rp, 1'b1, 0, 0);
        vectors++;
        if (ovr_w !== 3'b111) begin
            miscompares++;
            $display("FAIL overrun_set: got %b, required 111", ovr_w);
        end
        wait_done("overrun", n);
        extra = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done_w[0]) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL overrun_single_done: got %0d extra done, required 0", extra);
        end
        do_clear();
        vectors++;
        if (ovr_w !== 3'b000) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b, required 000", ovr_w);
        end
    endtask

    task automatic test_lookahead();
        logic [255:0] rp, gp;
        int n;
        rp = '0; gp = '0; rp[pix(4, 14)] = 1'b1; gp[pix(4, 15)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0);
        wait_done("lookahead", n);
        vectors++;
        if (kind_w[2] !== HIT_PIPE || kind_w[0] !== HIT_NONE) begin
            miscompares++;
            $display("FAIL lookahead_kind: got la1=%0d la0=%0d, required 1 0", kind_w[2], kind_w[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] rp, gp;
        int n;
        rp = '0; gp = '0; rp[pix(11, 14)] = 1'b1; gp[pix(11, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0);
        wait_done("b2b_first", n);
        rp = '0; rp[pix(0, 14)] = 1'b1;
        send_frame(rp, gp, 1'b1, 1, 0);
        wait_done("b2b_second", n);
        vectors++;
        if (n != 17) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d edges, required 17", n);
        end
    endtask

    task automatic test_clear_in_report();
        logic [255:0] rp, gp;
        int n;
        rp = '0; gp = '0; rp[pix(8, 14)] = 1'b1; gp[pix(8, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 1);
        repeat (16) @(posedge clk);
        #1;
        clear_s = 1'b1;
        @(posedge clk); #1;
        clear_s = 1'b0;
        vectors++;
        if (done_w !== 3'b111 || coll_w !== 3'b000) begin
            miscompares++;
            $display("FAIL clear_in_report: got done=%b coll=%b, required 111 000", done_w, coll_w);
        end
        send_frame(rp, gp, 1'b0, 1, 0);
        wait_done("after_clear_report", n);
    endtask

    task automatic test_reset_mid_scan();
        logic [255:0] rp, gp;
        int n;
        rp = '0; gp = '0; rp[pix(9, 14)] = 1'b1; gp[pix(9, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 0, 0);
        repeat (6) @(posedge clk);
        vectors++;
        if (coll_w !== {coll_m[2], coll_m[1], coll_m[0]} || busy_w !== 3'b111) begin
            miscompares++;
            $display("FAIL pre_reset: got coll=%b busy=%b, required %b 111", coll_w, busy_w,
                     {coll_m[2], coll_m[1], coll_m[0]});
        end
        #3 rst = 1'b0;
        #1;
        model_reset();
        test_reset();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        rp = '0; rp[pix(15, 14)] = 1'b1;
        send_frame(rp, gp, 1'b0, 1, 0);
        wait_done("after_reset", n);
    endtask

    initial begin
        rst = 1'b0; frame_valid_s = 1'b0; press_s = 1'b0; clear_s = 1'b0;
        red_s = '0; green_s = '0;
        model_reset();
        #12;
        test_reset();
        #11 rst = 1'b1;
        @(posedge clk); #1;
        test_pipe_basic();
        test_priority();
        test_grace();
        test_overrun();
        test_lookahead();
        test_back_to_back();
        test_clear_in_report();
        test_reset_mid_scan();
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", q0.size() + q1.size() + q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
